uart_tx_periph: RTL and testbench

// - Memory-mapped UART transmitter; responder on the core's data-memory port (we/addr/data/write_transfer),

---
 rtl/uart_tx_periph.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_periph                                               |
// | Description : Memory-mapped 8N1 UART transmitter on the core's data port.  |
// |               Stores to TXDATA queue bytes in a small FIFO; a bit-timed    |
// |               FSM drains the FIFO onto tx_o (idle high, LSB first).        |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               sel_i, we_i, addr_i, data_i, write_transfer_i : bus request  |
// |               data_o : registered read data (1-cycle latency)              |
// |               tx_o   : serial output                                       |
// |               irq_o  : TX-drained interrupt (only with UART_TX_IRQ_EN)     |
// | Options     : `define UART_TX_IRQ_EN adds irq_o and CTRL[1] irq_en.        |
// | Register map (addr_i[3:2]):                                                |
// |   0 TXDATA  W push byte, R 0                                               |
// |   1 STATUS  R {level[11:8], overrun, empty, full, busy}; W bit3 clears ovr |
// |   2 BAUDDIV RW clocks per bit [15:0], 0 behaves as 1                       |
// |   3 CTRL    RW [0] tx_en, [1] irq_en (option)                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_tx_periph #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [3:0]            write_transfer_i,
  output logic [DATA_WIDTH-1:0] data_o,
`ifdef UART_TX_IRQ_EN
  output logic                  irq_o,
`endif
  output logic                  tx_o
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  localparam logic [1:0] c_REG_TXDATA  = 2'd0;
  localparam logic [1:0] c_REG_STATUS  = 2'd1;
  localparam logic [1:0] c_REG_BAUDDIV = 2'd2;
  localparam logic [1:0] c_REG_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Register state
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_tx;
  logic [15:0]           r_cnt;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;

  logic [15:0]           r_baud_div;
  logic                  r_tx_en;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_data_o;

  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_LVL_W-1:0]    r_level;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic [1:0] w_reg;
  logic       w_wr;
  logic       w_rd;
  logic       w_push_req;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_busy;
  logic [15:0] w_div_m1;

  assign w_reg      = addr_i[3:2];
  assign w_wr       = sel_i & we_i;
  assign w_rd       = sel_i & ~we_i;
  assign w_full     = (r_level == c_LVL_W'(FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = w_wr & (w_reg == c_REG_TXDATA) & write_transfer_i[0];
  // Full is judged on the registered level, so a pop in the same cycle does
  // not make room for the incoming byte.
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & r_tx_en & ~w_empty;
  // A divider of zero is treated as one clock per bit.
  assign w_div_m1   = (r_baud_div == 16'd0) ? 16'd0 : (r_baud_div - 16'd1);

  // Bits of the bus that carry no information for this peripheral.
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, addr_i[ADDR_WIDTH-1:4], addr_i[1:0],
                           data_i[DATA_WIDTH-1:16], write_transfer_i[3:2]};

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
`ifdef UART_TX_IRQ_EN
  logic r_irq_en;
  logic r_irq;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_div <= 16'(DEFAULT_DIV);
      r_tx_en    <= 1'b1;
      r_overrun  <= 1'b0;
`ifdef UART_TX_IRQ_EN
      r_irq_en   <= 1'b0;
`endif
    end else begin
      if (w_push_req && w_full) begin
        r_overrun <= 1'b1;
      end
      if (w_wr) begin
        case (w_reg)
          c_REG_STATUS: begin
            if (write_transfer_i[0] && data_i[3]) begin
              r_overrun <= 1'b0;
            end
          end
          c_REG_BAUDDIV: begin
            if (write_transfer_i[0]) r_baud_div[7:0]  <= data_i[7:0];
            if (write_transfer_i[1]) r_baud_div[15:8] <= data_i[15:8];
          end
          c_REG_CTRL: begin
            if (write_transfer_i[0]) begin
              r_tx_en  <= data_i[0];
`ifdef UART_TX_IRQ_EN
              r_irq_en <= data_i[1];
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  // Storage needs no reset: only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Serialiser FSM: every bit lasts max(BAUDDIV,1) clocks; the divider is
  // sampled only at bit starts so a mid-frame write affects the next bit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_state <= S_START;
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_cnt   <= w_div_m1;
          end
        end
        S_START: begin
          if (r_cnt == 16'd0) begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_bit_idx <= 3'd0;
            r_cnt     <= w_div_m1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (r_cnt == 16'd0) begin
            r_cnt <= w_div_m1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_STOP: begin
          // Returning to IDLE costs one clock before the next START.
          if (r_cnt == 16'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o = r_tx;

  // --------------------------------------------------------------------------
  // Interrupt: TX fully drained and idle, delayed one clock
  // --------------------------------------------------------------------------
`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  assign irq_o = r_irq;
`endif

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    case (w_reg)
      c_REG_STATUS: begin
        w_rd_data[0]    = w_busy;
        w_rd_data[1]    = w_full;
        w_rd_data[2]    = w_empty;
        w_rd_data[3]    = r_overrun;
        w_rd_data[11:8] = 4'(r_level);
      end
      c_REG_BAUDDIV: w_rd_data[15:0] = r_baud_div;
      c_REG_CTRL: begin
        w_rd_data[0] = r_tx_en;
`ifdef UART_TX_IRQ_EN
        w_rd_data[1] = r_irq_en;
`endif
      end
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_o <= '0;
    end else if (w_rd) begin
      r_data_o <= w_rd_data;
    end
  end

  assign data_o = r_data_o;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_periph                                            |
// | Description : Directed self-checking bench for uart_tx_periph.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_tx_periph;

  logic        clk;
  logic        rst;
  logic        sel_i;
  logic        we_i;
  logic [9:0]  addr_i;
  logic [31:0] data_i;
  logic [3:0]  write_transfer_i;
  logic [31:0] data_o;
  logic        tx_o;
`ifdef UART_TX_IRQ_EN
  logic        irq_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [9:0] c_A_TXDATA  = 10'h000;
  localparam logic [9:0] c_A_STATUS  = 10'h004;
  localparam logic [9:0] c_A_BAUDDIV = 10'h008;
  localparam logic [9:0] c_A_CTRL    = 10'h00C;

  uart_tx_periph #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .DEFAULT_DIV(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sel_i           (sel_i),
    .we_i            (we_i),
    .addr_i          (addr_i),
    .data_i          (data_i),
    .write_transfer_i(write_transfer_i),
    .data_o          (data_o),
`ifdef UART_TX_IRQ_EN
    .irq_o           (irq_o),
`endif
    .tx_o            (tx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle write; returns on the negedge after the accepting posedge.
  task automatic bus_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; write_transfer_i = m;
    @(negedge clk);
    sel_i = 1'b0; we_i = 1'b0; write_transfer_i = 4'b0000;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
    @(negedge clk);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk);
    d = data_o;
    sel_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (tx_o !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    n_vec++;
    if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data_o: got %h want 00000000", data_o); end
`ifdef UART_TX_IRQ_EN
    n_vec++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq_o); end
`endif
    bus_read(c_A_STATUS, rd);
    n_vec++;
    if (rd !== 32'h4) begin n_err++; $display("FAIL reset_status: got %h want 00000004", rd); end
    bus_read(c_A_BAUDDIV, rd);
    n_vec++;
    if (rd !== 32'd16) begin n_err++; $display("FAIL reset_bauddiv: got %h want 00000010", rd); end
    bus_read(c_A_CTRL, rd);
    n_vec++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL reset_ctrl: got %h want 00000001", rd); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd;
    bus_write(c_A_CTRL, 32'h0000_0003, 4'b0001);
    bus_read(c_A_CTRL, rd);
    n_vec++;
`ifdef UART_TX_IRQ_EN
    if (rd !== 32'h3) begin n_err++; $display("FAIL ctrl_rw: got %h want 00000003", rd); end
`else
    if (rd !== 32'h1) begin n_err++; $display("FAIL ctrl_rw: got %h want 00000001", rd); end
`endif
    bus_write(c_A_CTRL, 32'h0000_0001, 4'b0001);
    bus_read(c_A_TXDATA, rd);
    n_vec++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL txdata_read: got %h want 00000000", rd); end
  endtask

  // 0xA5 at 4 clk/bit: start, 1,0,1,0,0,1,0,1, stop.
  task automatic test_frame();
    logic [31:0] rd;
    logic [9:0]  pat;
    pat = 10'b1_1010_0101_0; // index 0 = start bit
    bus_write(c_A_BAUDDIV, 32'd4, 4'b0011);
    bus_read(c_A_BAUDDIV, rd);
    n_vec++;
    if (rd !== 32'd4) begin n_err++; $display("FAIL bauddiv_rw: got %h want 00000004", rd); end
    bus_write(c_A_TXDATA, 32'h0000_00A5, 4'b0001);
    n_vec++;
    if (tx_o !== 1'b1) begin n_err++; $display("FAIL frame_pre_start: got %b want 1", tx_o); end
    @(negedge clk);
    // Keep STATUS selected for reading throughout the frame.
    sel_i = 1'b1; we_i = 1'b0; addr_i = c_A_STATUS;
    for (int i = 0; i < 40; i++) begin
      n_vec++;
      if (tx_o !== pat[i/4]) begin
        n_err++; $display("FAIL frame_bit clk=%0d: got %b want %b", i, tx_o, pat[i/4]);
      end
      if (i >= 1) begin
        n_vec++;
        if (data_o[0] !== 1'b1) begin n_err++; $display("FAIL frame_busy clk=%0d: got %b want 1", i, data_o[0]); end
      end
      @(negedge clk);
    end
    n_vec++;
    if (data_o[0] !== 1'b1) begin n_err++; $display("FAIL frame_busy_stop_end: got %b want 1", data_o[0]); end
    @(negedge clk);
    sel_i = 1'b0;
    n_vec++;
    if (data_o !== 32'h4) begin n_err++; $display("FAIL frame_idle_status: got %h want 00000004", data_o); end
    n_vec++;
    if (tx_o !== 1'b1) begin n_err++; $display("FAIL frame_idle_tx: got %b want 1", tx_o); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    bus_write(c_A_CTRL, 32'h0, 4'b0001);
    for (int i = 0; i < 5; i++) bus_write(c_A_TXDATA, 32'h10 + i, 4'b0001);
    bus_read(c_A_STATUS, rd);
    n_vec++;
    if (rd !== 32'h0000_040A) begin n_err++; $display("FAIL overrun_status: got %h want 0000040a", rd); end
    bus_write(c_A_STATUS, 32'h8, 4'b0001);
    bus_read(c_A_STATUS, rd);
    n_vec++;
    if (rd !== 32'h0000_0402) begin n_err++; $display("FAIL overrun_clear: got %h want 00000402", rd); end
  endtask

  // FIFO still full from test_overrun: enable TX and push in the very cycle
  // the first pop happens.
  task automatic test_full_pop();
    logic [7:0]  byte_rx;
    logic [31:0] rd;
    int          t;
    bus_write(c_A_BAUDDIV, 32'd1, 4'b0011);
    @(negedge clk);
    sel_i = 1'b1; we_i = 1'b1; addr_i = c_A_CTRL; data_i = 32'h1; write_transfer_i = 4'b0001;
    @(negedge clk);
    addr_i = c_A_TXDATA; data_i = 32'h55;
    @(negedge clk);
    we_i = 1'b0; write_transfer_i = 4'b0000; addr_i = c_A_STATUS;
    n_vec++;
    if (tx_o !== 1'b0) begin n_err++; $display("FAIL fullpop_start: got %b want 0", tx_o); end
    @(negedge clk);
    sel_i = 1'b0;
    n_vec++;
    if (data_o !== 32'h0000_0309) begin n_err++; $display("FAIL fullpop_status: got %h want 00000309", data_o); end
    for (int b = 0; b < 8; b++) begin
      if (b > 0) @(negedge clk);
      byte_rx[b] = tx_o;
    end
    @(negedge clk);
    n_vec++;
    if (tx_o !== 1'b1) begin n_err++; $display("FAIL fullpop_stop0: got %b want 1", tx_o); end
    n_vec++;
    if (byte_rx !== 8'h10) begin n_err++; $display("FAIL fullpop_byte0: got %h want 10", byte_rx); end
    for (int f = 1; f < 4; f++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (tx_o !== 1'b0 && t < 40);
      n_vec++;
      if (tx_o !== 1'b0) begin
        n_err++; $display("FAIL fullpop_timeout frame=%0d: got no start bit want one", f);
      end
      for (int b = 0; b < 8; b++) begin @(negedge clk); byte_rx[b] = tx_o; end
      @(negedge clk);
      n_vec++;
      if (tx_o !== 1'b1) begin n_err++; $display("FAIL fullpop_stop frame=%0d: got %b want 1", f, tx_o); end
      n_vec++;
      if (byte_rx !== 8'(8'h10 + f)) begin
        n_err++; $display("FAIL fullpop_byte frame=%0d: got %h want %h", f, byte_rx, 8'(8'h10 + f));
      end
    end
    repeat (3) @(negedge clk);
    bus_read(c_A_STATUS, rd);
    n_vec++;
    if (rd !== 32'h0000_000C) begin n_err++; $display("FAIL fullpop_drained: got %h want 0000000c", rd); end
    bus_write(c_A_STATUS, 32'h8, 4'b0001);
  endtask

  // 0xF0 at 4 clk/bit: data bit 3 (low) occupies clocks 16..19 after start.
  task automatic test_reset_mid();
    logic [31:0] rd;
    int          lows;
    bus_write(c_A_BAUDDIV, 32'd4, 4'b0011);
    bus_write(c_A_TXDATA, 32'hF0, 4'b0001);
    repeat (18) @(negedge clk);
    n_vec++;
    if (tx_o !== 1'b0) begin n_err++; $display("FAIL rstmid_bit3: got %b want 0", tx_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (tx_o !== 1'b1) begin n_err++; $display("FAIL rstmid_tx: got %b want 1", tx_o); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    n_vec++;
    if (lows !== 0) begin n_err++; $display("FAIL rstmid_quiet: got %0d low clks want 0", lows); end
    bus_read(c_A_STATUS, rd);
    n_vec++;
    if (rd !== 32'h4) begin n_err++; $display("FAIL rstmid_status: got %h want 00000004", rd); end
    bus_read(c_A_BAUDDIV, rd);
    n_vec++;
    if (rd !== 32'd16) begin n_err++; $display("FAIL rstmid_bauddiv: got %h want 00000010", rd); end
  endtask

  // BAUDDIV=0 behaves as 1 clk/bit; 0x00 gives start + 8 zeros + stop.
  task automatic test_div0_irq();
    bus_write(c_A_BAUDDIV, 32'd0, 4'b0011);
`ifdef UART_TX_IRQ_EN
    bus_write(c_A_CTRL, 32'h3, 4'b0001);
`endif
    bus_write(c_A_TXDATA, 32'h00, 4'b0001);
`ifdef UART_TX_IRQ_EN
    n_vec++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_before_push: got %b want 1", irq_o); end
`endif
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      n_vec++;
      if (tx_o !== (i >= 9)) begin
        n_err++; $display("FAIL div0_bit clk=%0d: got %b want %b", i, tx_o, (i >= 9));
      end
`ifdef UART_TX_IRQ_EN
      n_vec++;
      if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_in_frame clk=%0d: got %b want 0", i, irq_o); end
`endif
    end
    @(negedge clk);
`ifdef UART_TX_IRQ_EN
    n_vec++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b want 1", irq_o); end
    bus_write(c_A_TXDATA, 32'h00, 4'b0001);
    n_vec++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_hold_push: got %b want 1", irq_o); end
    @(negedge clk);
    n_vec++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b want 0", irq_o); end
    repeat (15) @(negedge clk);
    bus_write(c_A_CTRL, 32'h1, 4'b0001);
`endif
  endtask

  initial begin
    rst = 1'b1; sel_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; write_transfer_i = '0;
    test_reset();
    test_ctrl();
    test_frame();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    test_div0_irq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case a task stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
